// File: rtl/codec_capture.sv
// rtl/codec_capture.sv - captures one ADC sample per codec frame into a FWFT FIFO
module codec_capture #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_frame,
    input  logic [WIDTH-1:0]      codec_sample,
    input  logic                  enable,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_sample,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sample_captured,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count,
    input  logic                  overflow_clear
);

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DROP_W-1:0]    DROP_ONE   = DROP_W'(1);
    localparam logic [DROP_W-1:0]    DROP_MAX   = '1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  nf_d;

    logic frame_edge;
    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Handshake and accept/drop decisions; flush swallows a coincident push silently
    always_comb begin
        frame_edge = new_frame & ~nf_d;
        push_req   = frame_edge & enable;
        pop        = out_valid & out_ready;
        full       = (fifo_count == FULL_COUNT);
        push_ok    = push_req & (~full | pop);
        drop       = push_req & ~push_ok & ~flush;
        out_valid  = (fifo_count != '0);
        out_sample = mem[rd_ptr];
    end

    // Sample storage; contents are never reset, only pointers and count are
    always_ff @(posedge clk) begin
        if (!reset && push_ok && !flush) begin
            mem[wr_ptr] <= codec_sample;
        end
    end

    // Frame edge history, pointers, occupancy and capture pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            nf_d            <= 1'b1;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            sample_captured <= 1'b0;
        end else begin
            nf_d <= new_frame;
            if (flush) begin
                rd_ptr          <= wr_ptr;
                fifo_count      <= '0;
                sample_captured <= 1'b0;
            end else begin
                sample_captured <= push_ok;
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push_ok, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_ONE;
                    2'b01:   fifo_count <= fifo_count - CNT_ONE;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clear) begin
                drop_count <= DROP_ONE;
            end else if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_ONE;
            end
        end else if (overflow_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_codec_capture.sv
// tb/tb_codec_capture.sv - scoreboard bench for codec_capture
module tb_codec_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_frame;
    logic [15:0] codec_sample;
    logic        enable;
    logic        flush;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        sample_captured;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        overflow_clear;

    int n_checks = 0;
    int n_fails  = 0;
    int caps     = 0;
    logic [15:0] sb [$];

    codec_capture #(.WIDTH(16), .DEPTH_LOG2(4), .DROP_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .new_frame       (new_frame),
        .codec_sample    (codec_sample),
        .enable          (enable),
        .flush           (flush),
        .out_sample      (out_sample),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sample_captured (sample_captured),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .drop_count      (drop_count),
        .overflow_clear  (overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        caps += int'(sample_captured);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        caps = 0;
    endtask

    // One frame: new_frame high for hi cycles then low for one; push expectation if accepted
    task automatic frame(input logic [15:0] s, input int hi, input bit accept);
        codec_sample = s;
        new_frame    = 1'b1;
        if (accept) sb.push_back(s);
        repeat (hi) tick();
        new_frame = 1'b0;
        tick();
    endtask

    // Monitor: compare head of FIFO against scoreboard on every handshake
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 32'(out_sample), 32'hdead);
            end else begin
                check("pop_sample", 32'(out_sample), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; new_frame = 1'b0; codec_sample = '0; enable = 1'b1;
        flush = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;

        // Reset state
        do_reset();
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_captured", 32'(sample_captured), 0);

        // Single 3-cycle frame yields exactly one capture
        caps = 0;
        frame(16'h1234, 3, 1'b1);
        check("t1_caps", 32'(caps), 1);
        check("t1_count", 32'(fifo_count), 1);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_sample", 32'(out_sample), 32'h1234);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_drained", 32'(fifo_count), 0);

        // new_frame high through reset release
        new_frame = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        caps = 0;
        tick(); tick(); tick();
        new_frame = 1'b0;
        tick();
        check("t2_caps", 32'(caps), 0);
        check("t2_count", 32'(fifo_count), 0);

        // 20 frames into a 16-deep FIFO
        do_reset();
        for (int i = 1; i <= 20; i++) frame(16'(i), 1, i <= 16);
        check("t3_count", 32'(fifo_count), 16);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_drop", 32'(drop_count), 4);

        // Full FIFO, frame edge with a coincident pop is accepted
        codec_sample = 16'h0100;
        new_frame    = 1'b1;
        out_ready    = 1'b1;
        sb.push_back(16'h0100);
        tick();
        new_frame = 1'b0;
        out_ready = 1'b0;
        tick();
        check("t4_count", 32'(fifo_count), 16);
        check("t4_drop", 32'(drop_count), 4);
        check("t4_head", 32'(out_sample), 2);

        // Drain: 2..16 then 16'h0100
        out_ready = 1'b1;
        repeat (16) tick();
        check("t3_empty_valid", 32'(out_valid), 0);
        check("t3_sb_empty", 32'(sb.size()), 0);
        tick();
        out_ready = 1'b0;
        check("t3_no_underflow", 32'(fifo_count), 0);

        // Drop counter saturation, then clear coincident with a drop
        do_reset();
        for (int i = 0; i < 300; i++) frame(16'(i + 16'h0200), 1, sb.size() < 16);
        check("t5_sat", 32'(drop_count), 255);
        check("t5_overflow", 32'(overflow), 1);
        new_frame      = 1'b1;
        overflow_clear = 1'b1;
        tick();
        new_frame      = 1'b0;
        overflow_clear = 1'b0;
        check("t5_clr_set_ovf", 32'(overflow), 1);
        check("t5_clr_set_drop", 32'(drop_count), 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 0);
        check("t5_clr_drop", 32'(drop_count), 0);
        tick();

        // Flush with coincident frame edge and pop
        do_reset();
        sb.delete();
        for (int i = 0; i < 5; i++) frame(16'(16'h0300 + i), 1, 1'b1);
        check("t6_count5", 32'(fifo_count), 5);
        flush        = 1'b1;
        new_frame    = 1'b1;
        out_ready    = 1'b1;
        codec_sample = 16'h0BAD;
        sb.delete();
        tick();
        flush     = 1'b0;
        new_frame = 1'b0;
        out_ready = 1'b0;
        check("t6_count", 32'(fifo_count), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_drop", 32'(drop_count), 0);
        check("t6_captured", 32'(sample_captured), 0);
        tick();

        // Disabled capture: no capture, no drop, FIFO still drains
        frame(16'h0401, 1, 1'b1);
        frame(16'h0402, 1, 1'b1);
        enable = 1'b0;
        caps = 0;
        out_ready = 1'b1;
        frame(16'h0BEE, 1, 1'b0);
        frame(16'h0BEF, 1, 1'b0);
        out_ready = 1'b0;
        check("t7_caps", 32'(caps), 0);
        check("t7_count", 32'(fifo_count), 0);
        check("t7_drop", 32'(drop_count), 0);
        check("t7_sb_empty", 32'(sb.size()), 0);
        enable = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
